param_shadow_chk: RTL and testbench
===================================

Name: param_shadow_chk

Overview:
Self-checking multi-channel counter sequencer for the regression suite.
- Wildcard-imports the shared package and declares its own module parameter NUM.
- Per IEEE 1800 section 26.3, the local NUM takes precedence over the package NUM. All run-length and expected-value arithmetic must use the local NUM.
- Runs NUM_CH weighted counters for NUM cycles, checks each against a closed-form expected value, then reports pass/fail.
- Sits as the DUT under a bench top that drives start/inject and calls $finish or $stop on the result.

Parameters:
NUM, 32, run length in cycles; module-local, shadows package NUM (8); legal range 1..2^16-1
NUM_CH, 4, channel count; legal range 1..16
W, 8, counter width per channel; legal range 2..32

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
chan_en  input  NUM_CH  per-channel enable; latched at start
inj_en  input  1  fault inject; sampled only in RUN
inj_ch  input  $clog2(NUM_CH) or 1, whichever is larger  channel receiving the fault
busy  output  1  high in RUN and CHECK
done  output  1  one-cycle pulse in DONE
pass  output  1  result of last run; valid from done until the next start
fail_ch  output  $clog2(NUM_CH) or 1, whichever is larger  lowest failing channel index; 0 if pass
run_cnt  output  16  cycles elapsed in current RUN

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; all counters=0; busy=0; done=0; pass=0; fail_ch=0; run_cnt=0; latched enables=0. Reset asserted mid-RUN or mid-CHECK aborts immediately; no done pulse is issued.
- States: IDLE, RUN, CHECK, DONE (enum in package).
- IDLE:
  - start=1 at edge k: latch chan_en; clear counters, run_cnt, pass, fail_ch; enter RUN at k+1.
  - start is ignored in every other state.
- RUN, one cycle per edge, for exactly NUM cycles:
  - Each enabled channel c adds (c+1) to its counter, modulo 2^W (wrap, no saturate).
  - If inj_en=1 and inj_ch==c, channel c skips its add that cycle. inj_ch >= NUM_CH is ignored.
  - Disabled channels hold 0.
  - run_cnt increments each RUN cycle. After the NUM-th increment, move to CHECK.
- CHECK, one channel per cycle, c = 0..NUM_CH-1:
  - expected = ((c+1)*NUM) mod 2^W if enabled, else 0. Compute the product at width W+16, then truncate.
  - On the first mismatch, record fail_ch=c and a fail flag. Later mismatches do not overwrite fail_ch.
  - After channel NUM_CH-1, move to DONE.
- DONE, one cycle: done=1; pass = no mismatch; busy=0. Next state IDLE.
- Latency: start sampled at edge k, so done is high during cycle k+1+NUM+NUM_CH (for example, k+37 with defaults).
- start held high through DONE: a new run begins only from IDLE, so at least one idle cycle separates runs.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package defs_pkg holds:
  - parameter NUMBER = 8
  - localparam NUM = NUMBER (deliberately shadowed)
  - typedef enum logic [1:0] state_t {IDLE, RUN, CHECK, DONE}
- Sub-module ch_counter (params W, INC): one channel's enable/skip/wrap counter, instantiated NUM_CH times via generate.
- FSM and checker live in param_shadow_chk.

Test Plan:
- Defaults, chan_en=4'b1111, start pulse at cycle 2 -> done at cycle 39; counters 32,64,96,128; pass=1; fail_ch=0. Also confirms the run uses NUM=32, not the package value 8.
- NUM_CH=8, W=8, all enabled -> channel 7 expected 256 mod 256 = 0 (wrap); pass=1.
- inj_en=1, inj_ch=2 for one RUN cycle -> counter2=93, expected 96; pass=0; fail_ch=2.
- Inject on channels 1 and 3 in separate cycles -> fail_ch=1 (lowest index wins); pass=0.
- chan_en=4'b0101 -> counters 32,0,96,0; pass=1. inj_en on disabled channel 1 -> no effect; pass=1.
- rst_n=0 at run_cnt=10 -> next cycle IDLE; all outputs 0; no done pulse. A fresh start after release completes normally.

Source files
------------

// File: rtl/defs_pkg.sv
// Shared definitions for the param_shadow_chk sequencer and its interface.
// The package carries its own NUM on purpose; the sequencer declares a
// module-local NUM that must take precedence over this one.
package defs_pkg;

  parameter int NUMBER = 8;
  localparam int NUM = NUMBER;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  // Index width for a channel count, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_shadow_chk_if.sv
// Control/status bundle between the bench top and the sequencer.
interface param_shadow_chk_if #(parameter int NUM_CH = 4);
  import defs_pkg::*;

  localparam int CW = idx_w(NUM_CH);

  logic              start;
  logic [NUM_CH-1:0] chan_en;
  logic              inj_en;
  logic [CW-1:0]     inj_ch;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CW-1:0]     fail_ch;
  logic [15:0]       run_cnt;

  modport master (
    output start, chan_en, inj_en, inj_ch,
    input  busy, done, pass, fail_ch, run_cnt
  );

  modport slave (
    input  start, chan_en, inj_en, inj_ch,
    output busy, done, pass, fail_ch, run_cnt
  );

endinterface

// File: rtl/param_shadow_chk_ch_counter.sv
// One weighted channel counter: adds INC per enabled cycle, wrapping mod 2^W.
module ch_counter #(
  parameter int W   = 8,
  parameter int INC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Clear at run start, otherwise accumulate the channel weight when enabled
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(INC);
  end

endmodule

// File: rtl/param_shadow_chk.sv
// Multi-channel counter sequencer: runs NUM_CH weighted counters for NUM
// cycles, then checks each against (c+1)*NUM mod 2^W and reports the result.
// NUM here is the module parameter; it shadows the package constant of the
// same name, so all run-length and expected-value math uses the local value.
module param_shadow_chk #(
  parameter int NUM    = 32,
  parameter int NUM_CH = 4,
  parameter int W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  param_shadow_chk_if.slave bus
);
  import defs_pkg::*;

  localparam int CW = idx_w(NUM_CH);

  state_t            state;
  logic [NUM_CH-1:0] en_lat;
  logic [CW-1:0]     chk_idx;
  logic              fail_flag;
  logic [W-1:0]      cnt [NUM_CH];
  logic              clr;
  logic              run;
  logic [W-1:0]      sel_cnt;
  logic [W-1:0]      sel_exp;
  logic [W+15:0]     prod;
  logic              mismatch;
  logic              last_ch;
  logic              run_last;

  assign clr      = (state == IDLE) && bus.start;
  assign run      = (state == RUN);
  assign last_ch  = (chk_idx == CW'(NUM_CH - 1));
  assign run_last = (bus.run_cnt == 16'(NUM - 1));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_counter #(.W(W), .INC(c + 1)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (run && en_lat[c] && !(bus.inj_en && (bus.inj_ch == CW'(c)))),
      .cnt   (cnt[c])
    );
  end

  // Select the channel under check and its closed-form expected value
  always_comb begin
    sel_cnt = '0;
    sel_exp = '0;
    prod    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chk_idx == CW'(c)) begin
        sel_cnt = cnt[c];
        prod    = (W+16)'(c + 1) * (W+16)'(NUM);
        sel_exp = en_lat[c] ? prod[W-1:0] : '0;
      end
    end
  end

  assign mismatch = (state == CHECK) && (sel_cnt != sel_exp);

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      en_lat      <= '0;
      chk_idx     <= '0;
      fail_flag   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
      bus.fail_ch <= '0;
      bus.run_cnt <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            en_lat      <= bus.chan_en;
            chk_idx     <= '0;
            fail_flag   <= 1'b0;
            bus.run_cnt <= '0;
            bus.pass    <= 1'b0;
            bus.fail_ch <= '0;
            bus.busy    <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          bus.run_cnt <= bus.run_cnt + 16'd1;
          if (run_last) state <= CHECK;
        end
        CHECK: begin
          if (mismatch && !fail_flag) begin
            fail_flag   <= 1'b1;
            bus.fail_ch <= chk_idx;
          end
          if (last_ch) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= !(fail_flag || mismatch);
            state    <= DONE;
          end else begin
            chk_idx <= chk_idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_shadow_chk.sv
// Scoreboard bench for param_shadow_chk: each run's expected result is
// modelled and queued at start, then popped and compared when done pulses.
module tb_param_shadow_chk;

  localparam int NUM = 32;

  typedef struct {
    bit pass;
    int fail_ch;
    int start_cyc;
    int nch;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total_checks = 0;
  int   bad_checks = 0;
  exp_t sb[$];

  param_shadow_chk_if #(.NUM_CH(4)) bus ();
  param_shadow_chk_if #(.NUM_CH(8)) bus8 ();

  param_shadow_chk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  param_shadow_chk #(.NUM_CH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input int got, input int want);
    total_checks++;
    if (got !== want) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Model a run of the 4-channel DUT with up to two one-cycle injections
  // (ch < 0 means unused), drive it, and check the result when done pulses
  task automatic applyStimulus(input logic [3:0] en, input int a_cyc, input int a_ch,
                               input int b_cyc, input int b_ch);
    exp_t e;
    int   skips;
    int   got;
    int   want;
    int   n;
    e.pass = 1'b1;
    e.fail_ch = 0;
    e.nch = 4;
    for (int c = 0; c < 4; c++) begin
      skips = 0;
      if (a_ch == c) skips++;
      if (b_ch == c) skips++;
      if (en[c]) begin
        got  = ((c + 1) * (NUM - skips)) % 256;
        want = ((c + 1) * NUM) % 256;
        if (got != want && e.pass) begin
          e.pass = 1'b0;
          e.fail_ch = c;
        end
      end
    end
    @(negedge clk);
    bus.start   = 1'b1;
    bus.chan_en = en;
    e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.chan_en = ~en;
    checkOutput("busy_in_run", bus.busy, 1);
    checkOutput("run_cnt_start", bus.run_cnt, 0);
    for (int i = 0; i < NUM; i++) begin
      bus.start  = (i == 5);
      bus.inj_en = ((i == a_cyc) && (a_ch >= 0)) || ((i == b_cyc) && (b_ch >= 0));
      bus.inj_ch = (i == b_cyc) ? 2'(b_ch) : 2'(a_ch);
      @(negedge clk);
      if (i == 9) checkOutput("run_cnt_mid", bus.run_cnt, 10);
    end
    bus.start  = 1'b0;
    bus.inj_en = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", bus.done, 1);
    if (bus.done && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("pass", bus.pass, e.pass);
      checkOutput("fail_ch", bus.fail_ch, e.fail_ch);
      checkOutput("latency", cyc - e.start_cyc, 1 + NUM + e.nch);
      checkOutput("busy_at_done", bus.busy, 0);
      checkOutput("run_cnt_final", bus.run_cnt, NUM);
      @(negedge clk);
      checkOutput("done_pulse_len", bus.done, 0);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  // Run the 8-channel DUT, all enabled, with an optional single injection
  task automatic applyStimulus8(input int a_cyc, input int a_ch);
    exp_t e;
    int   got;
    int   want;
    int   n;
    e.pass = 1'b1;
    e.fail_ch = 0;
    e.nch = 8;
    for (int c = 0; c < 8; c++) begin
      got  = ((c + 1) * (NUM - ((a_ch == c) ? 1 : 0))) % 256;
      want = ((c + 1) * NUM) % 256;
      if (got != want && e.pass) begin
        e.pass = 1'b0;
        e.fail_ch = c;
      end
    end
    @(negedge clk);
    bus8.start   = 1'b1;
    bus8.chan_en = 8'hFF;
    e.start_cyc  = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      bus8.inj_en = (i == a_cyc) && (a_ch >= 0);
      bus8.inj_ch = 3'(a_ch);
      @(negedge clk);
    end
    bus8.inj_en = 1'b0;
    n = 0;
    while (!bus8.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen8", bus8.done, 1);
    if (bus8.done && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("pass8", bus8.pass, e.pass);
      checkOutput("fail_ch8", bus8.fail_ch, e.fail_ch);
      checkOutput("latency8", cyc - e.start_cyc, 1 + NUM + e.nch);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  // Abort a run with reset at run_cnt=10 and confirm no done follows
  task automatic applyMidRunReset();
    int n;
    int hits;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.chan_en = 4'b1111;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.run_cnt != 16'd10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_run_cnt_10", bus.run_cnt, 10);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_run_cnt", bus.run_cnt, 0);
    checkOutput("abort_pass", bus.pass, 0);
    checkOutput("abort_fail_ch", bus.fail_ch, 0);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done) hits++;
    end
    checkOutput("no_done_after_abort", hits, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.chan_en  = '0;
    bus.inj_en   = 1'b0;
    bus.inj_ch   = '0;
    bus8.start   = 1'b0;
    bus8.chan_en = '0;
    bus8.inj_en  = 1'b0;
    bus8.inj_ch  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_pass", bus.pass, 0);
    checkOutput("rst_fail_ch", bus.fail_ch, 0);
    checkOutput("rst_run_cnt", bus.run_cnt, 0);
    rst_n = 1'b1;

    $display("[TB] all channels, no injection");
    applyStimulus(4'b1111, -1, -1, -1, -1);
    $display("[TB] inject channel 2 once");
    applyStimulus(4'b1111, 7, 2, -1, -1);
    $display("[TB] inject channels 3 and 1 in separate cycles");
    applyStimulus(4'b1111, 4, 3, 12, 1);
    $display("[TB] sparse enables with injection on a disabled channel");
    applyStimulus(4'b0101, 3, 1, -1, -1);
    $display("[TB] eight channels, wrap on channel 7");
    applyStimulus8(-1, -1);
    applyStimulus8(20, 7);
    $display("[TB] reset mid-run then fresh run");
    applyMidRunReset();
    applyStimulus(4'b1111, -1, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
